div_hilo_ctrl: RTL
==================

// Module: div_hilo_ctrl
// PURPOSE
//  Sequencer wrapped around the combinational divider. Latches dividend/divisor from the A/B regs and drives
//  the divider inputs (upstream side). Holds them stable for DIV_WAIT cycles as a multicycle settle window.
//  Captures remainder/quotient into architectural HI/LO (downstream side) and reports done / divide-by-zero
//  to the main control FSM. Also services mthi/mtlo writes.
// PARAMETERS
//  DATA_W    32  operand/result width
//  DIV_WAIT  4   settle cycles between operand latch and HI/LO capture; legal range 1..15
//  CNT_W     4   wait-counter width; must satisfy 2**CNT_W > DIV_WAIT
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       synchronous, active-low (0 = reset)
//  div_start     in   1       request from control FSM, sampled each edge
//  a_in          in   DATA_W  dividend (A register)
//  b_in          in   DATA_W  divisor (B register)
//  Divsrca       out  DATA_W  latched dividend -> divider
//  Divsrcb       out  DATA_W  latched divisor  -> divider
//  DivHI         in   DATA_W  remainder from divider
//  DivLO         in   DATA_W  quotient from divider
//  by_zero       in   1       divider divisor==0 flag
//  hi_write      in   1       mthi strobe
//  lo_write      in   1       mtlo strobe
//  mt_data       in   DATA_W  mthi/mtlo data
//  div_busy      out  1       1 while in WAIT
//  div_done      out  1       one-cycle completion pulse
//  div_zero_exc  out  1       one-cycle pulse coincident with div_done when divisor was 0
//  HI_out        out  DATA_W  HI register
//  LO_out        out  DATA_W  LO register
// BEHAVIOUR
//  Reset (reset==0 at an edge)
//   - State IDLE. All outputs 0: Divsrca, Divsrcb, HI_out, LO_out, busy, done, exc. Counter 0.
//   - Reset mid-operation aborts: no done pulse is issued and HI/LO are cleared.
//  States: IDLE, WAIT, DONE.
//   - IDLE: div_start=1 -> latch a_in/b_in into Divsrca/Divsrcb, counter<=DIV_WAIT-1, go WAIT.
//   - WAIT: busy=1. Counter decrements each edge. At the edge where counter==0:
//     - by_zero=0: HI_out<=DivHI, LO_out<=DivLO.
//     - by_zero=1: HI/LO unchanged, exc flag set.
//     - Go to DONE.
//   - DONE: done=1 (exc=1 if flagged), busy=0. Next edge: exc cleared.
//     - div_start=1 in DONE is accepted exactly as in IDLE (back-to-back; go WAIT).
//     - Otherwise go IDLE.
//  Latency: div_start sampled at edge 0 -> busy during cycles 1..DIV_WAIT -> done in cycle DIV_WAIT+1.
//  Divsrca/Divsrcb change only on an accepted start; held stable through WAIT and afterwards.
//  div_start during WAIT is ignored (not queued).
//  hi_write/lo_write: honoured in IDLE/DONE only; ignored while busy, including the capture edge.
//   - Both strobes at once write both registers.
//   - Strobe plus accepted start on the same edge: mt write happens; the later div result overwrites.
//  Arithmetic is unsigned (divider's). Controller never modifies data: HI=remainder, LO=quotient.
// STRUCTURE
//  - Shared package div_pkg: state enum {IDLE,WAIT,DONE}, DATA_W default, DIV_WAIT default.
//  - One sub-module: div_wait_counter (load/decrement/zero flag, CNT_W wide).
//  - Divider stays a separate instance at the level above; this block only connects to its ports.
// TESTING
//  1. a=100, b=7, DIV_WAIT=4, start @c0
//     -> busy c1..c4; done c5; LO=14, HI=2; exc=0; Divsrca=100, Divsrcb=7 held.
//  2. Preload HI=0xAAAA, LO=0x5555 via mthi/mtlo; a=5, b=0
//     -> done+exc c5; HI/LO still 0xAAAA/0x5555; exc 0 at c6.
//  3. start a=9, b=2; pulse start again @c2 with a=50, b=5
//     -> second ignored; LO=4, HI=1; exactly one done pulse.
//  4. start a=100, b=7; reset=0 @c3
//     -> c4: all outputs 0, IDLE, no done; start @c5 a=8, b=3 -> done c10, LO=2, HI=2.
//  5. Back-to-back: start in DONE cycle with a=20, b=6
//     -> next done 5 cycles later; LO=3, HI=2; busy never drops between ops except DONE cycle.
//  6. hi_write=1, mt_data=0x1234 during WAIT -> ignored; the same in IDLE -> HI=0x1234 next cycle, LO unchanged.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide sequencer.
//   div_state_e  : sequencer states (IDLE, WAIT, DONE)
//   *_DEF        : default widths/latencies used by div_hilo_ctrl
package div_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DIV_WAIT_DEF = 4;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_wait_counter.sv
// Settle-window down counter for the divide sequencer.
//   clk, reset : clock, synchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement, saturating at zero
//   zero       : counter currently equals zero
module div_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)                    cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequencer around the external combinational divider.
// Latches dividend/divisor on an accepted start, holds them for a DIV_WAIT
// cycle settle window, then captures remainder/quotient into HI/LO.
//   clk, reset          : clock, synchronous active-low reset
//   div_start           : start request (accepted in IDLE or DONE)
//   a_in, b_in          : dividend / divisor
//   Divsrca, Divsrcb    : latched operands driving the divider
//   DivHI, DivLO        : remainder / quotient from the divider
//   by_zero             : divider flags divisor == 0
//   hi_write, lo_write  : mthi / mtlo strobes, mt_data is the write data
//   div_busy            : high while in WAIT
//   div_done            : one-cycle completion pulse (DONE state)
//   div_zero_exc        : one-cycle pulse with div_done when divisor was 0
//   HI_out, LO_out      : architectural HI / LO
module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DIV_WAIT = DIV_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] Divsrca,
  output logic [DATA_W-1:0] Divsrcb,
  input  logic [DATA_W-1:0] DivHI,
  input  logic [DATA_W-1:0] DivLO,
  input  logic              by_zero,
  input  logic              hi_write,
  input  logic              lo_write,
  input  logic [DATA_W-1:0] mt_data,
  output logic              div_busy,
  output logic              div_done,
  output logic              div_zero_exc,
  output logic [DATA_W-1:0] HI_out,
  output logic [DATA_W-1:0] LO_out
);

  div_state_e state_q, state_d;
  logic       start_acc, capture, cnt_zero, exc_q;

  div_wait_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (CNT_W'(DIV_WAIT - 1)),
    .dec      (div_busy),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    capture   = 1'b0;
    div_busy  = 1'b0;
    div_done  = 1'b0;
    case (state_q)
      IDLE: begin
        start_acc = div_start;
        if (div_start) state_d = WAIT;
      end
      WAIT: begin
        div_busy = 1'b1;
        capture  = cnt_zero;
        if (cnt_zero) state_d = DONE;
      end
      DONE: begin
        div_done  = 1'b1;
        start_acc = div_start;
        state_d   = div_start ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      Divsrca <= '0;
      Divsrcb <= '0;
      HI_out  <= '0;
      LO_out  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Flag lives exactly one cycle: set on the capture edge, seen in DONE.
      exc_q   <= capture && by_zero;
      if (start_acc) begin
        Divsrca <= a_in;
        Divsrcb <= b_in;
      end
      // mt writes are blocked for all of WAIT, so the capture edge never races them.
      if (capture) begin
        if (!by_zero) begin
          HI_out <= DivHI;
          LO_out <= DivLO;
        end
      end else if (!div_busy) begin
        if (hi_write) HI_out <= mt_data;
        if (lo_write) LO_out <= mt_data;
      end
    end
  end

  assign div_zero_exc = exc_q;

endmodule
